// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - op codes, FSM states and default width for alu_seq
package alu_seq_pkg;

  localparam int ALU_SEQ_W = 8;

  typedef enum logic [2:0] {
    OP_XOR  = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_DIV  = 3'd5,
    OP_MOD  = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // DIV and MOD share the iterative divider
  function automatic logic is_divmod(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_seq_div.sv
// rtl/alu_seq_div.sv - restoring divider, one quotient bit per step
module alu_seq_div
  import alu_seq_pkg::*;
#(
  parameter int W = ALU_SEQ_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  // values after the step taken this cycle; valid on the final step
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  logic [W-1:0] r_rem;
  logic [W-1:0] r_quo;
  logic [W-1:0] r_dvs;
  logic [W:0]   w_trial;
  logic         w_fit;
  logic [W-1:0] w_rem_nxt;
  logic [W-1:0] w_quo_nxt;

  // shift the next dividend bit into the partial remainder and try a subtract
  always_comb begin
    w_trial   = {r_rem, r_quo[W-1]} - {1'b0, r_dvs};
    w_fit     = ~w_trial[W];
    w_rem_nxt = w_fit ? w_trial[W-1:0] : {r_rem[W-2:0], r_quo[W-1]};
    w_quo_nxt = {r_quo[W-2:0], w_fit};
  end

  assign quotient  = w_quo_nxt;
  assign remainder = w_rem_nxt;

  // dividend bits are consumed from r_quo as quotient bits shift in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
    end else if (load) begin
      r_rem <= '0;
      r_quo <= dividend;
      r_dvs <= divisor;
    end else if (step) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with iterative DIV/MOD; ALU_SEQ_FLAGS_EN enables flags
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int W = ALU_SEQ_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic [2:0]   flags
);

  localparam int CW = $clog2(W + 1);

  state_e       r_state;
  state_e       w_state_nxt;
  op_e          r_op;
  op_e          w_sel_op;
  logic [CW-1:0] r_cnt;
  logic [W-1:0] r_result;
  logic [W-1:0] w_res;
  logic [W-1:0] w_quo;
  logic [W-1:0] w_rem;
  logic         w_accept;
  logic         w_div_start;
  logic         w_calc;
  logic         w_last;
  logic         w_wr;

`ifdef ALU_SEQ_FLAGS_EN
  logic [W:0]   w_sum;
  logic [W:0]   w_diff;
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};
`else
  logic [W-1:0] w_sum;
  logic [W-1:0] w_diff;
  assign w_sum  = a + b;
  assign w_diff = a - b;
`endif

  assign w_accept    = start && (r_state == ST_IDLE);
  assign w_div_start = w_accept && is_divmod(op) && (b != '0);
  assign w_calc      = (r_state == ST_CALC);
  assign w_last      = w_calc && (r_cnt == '0);
  // single-cycle results land on the accept edge, divider results on the last step
  assign w_wr        = (w_accept && !w_div_start) || w_last;
  // the accept edge needs the live op; during CALC the captured op picks DIV or MOD
  assign w_sel_op    = (r_state == ST_IDLE) ? op_e'(op) : r_op;

  assign busy   = (r_state != ST_IDLE);
  assign done   = (r_state == ST_DONE);
  assign result = r_result;

  alu_seq_div #(.W(W)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (w_div_start),
    .step      (w_calc),
    .dividend  (a),
    .divisor   (b),
    .quotient  (w_quo),
    .remainder (w_rem)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // next state: divide by zero skips CALC, DONE always lasts one cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_div_start ? ST_CALC : ST_DONE;
      ST_CALC: if (r_cnt == '0) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // iteration counter and captured op for the CALC phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_op  <= OP_XOR;
    end else begin
      if (w_accept) r_op <= op_e'(op);
      if (w_div_start)             r_cnt <= CW'(W - 1);
      else if (w_calc && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
  end

  // result multiplexer
  always_comb begin
    w_res = '0;
    case (w_sel_op)
      OP_XOR:  w_res = a ^ b;
      OP_ADD:  w_res = w_sum[W-1:0];
      OP_SUB:  w_res = w_diff[W-1:0];
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_DIV:  w_res = w_calc ? w_quo : '1;
      OP_MOD:  w_res = w_calc ? w_rem : a;
      OP_RSVD: w_res = '0;
      default: w_res = '0;
    endcase
  end

  // result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_result <= '0;
    else if (w_wr) r_result <= w_res;
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic       w_carry;
  logic       w_dz;
  logic [2:0] r_flags;

  // carry/borrow from the wide add/sub, dz only for the skipped-divide path
  always_comb begin
    w_carry = 1'b0;
    w_dz    = 1'b0;
    case (w_sel_op)
      OP_ADD:  w_carry = w_sum[W];
      OP_SUB:  w_carry = w_diff[W];
      OP_DIV,
      OP_MOD:  w_dz = !w_calc;
      default: w_carry = 1'b0;
    endcase
  end

  // flags register, written together with the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_flags <= '0;
    else if (w_wr) r_flags <= {w_dz, w_carry, (w_res == '0)};
  end

  assign flags = r_flags;
`else
  assign flags = 3'b000;
`endif

endmodule
